// File: rtl/dot_result_uart_tx.sv
// dot_result_uart_tx
// UART (8N1, LSB first) transmitter that reports a captured 16-bit dot-product
// result as a 6-character ASCII line: four uppercase hex digits or "OFLO",
// followed by CR LF. The final stop bit ends on a one-cycle done pulse, and
// busy is already low in that cycle so a new line can follow with no gap.

module dot_result_uart_tx #(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 115200
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] result16,
    input  logic        oflo,
    output logic        tx,
    output logic        busy,
    output logic        done
);

    localparam int DIV_RAW  = CLK_FREQ / BAUD;
    localparam int BAUD_DIV = (DIV_RAW < 2) ? 2 : DIV_RAW;
    localparam int CNT_W    = $clog2(BAUD_DIV);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);
    // The last line's final stop bit hands over to IDLE one cycle early so
    // that the done cycle itself is the last cycle of that stop bit.
    localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(BAUD_DIV - 2);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t            state_r;
    logic [CNT_W-1:0]  baud_cnt_r;
    logic [2:0]        bit_idx_r;
    logic [2:0]        char_idx_r;
    logic [15:0]       value_r;
    logic              oflo_r;
    logic              tx_r;
    logic              busy_r;
    logic              done_r;
    logic [7:0]        cur_byte_s;

    // Map one nibble to its uppercase ASCII hex digit.
    function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
        logic [7:0] r;
        if (nib < 4'd10) begin
            r = 8'h30 + {4'd0, nib};
        end else begin
            r = 8'h37 + {4'd0, nib};
        end
        return r;
    endfunction

    // Byte number idx of the line for a latched value / overflow flag.
    function automatic logic [7:0] line_byte(input logic [15:0] val,
                                             input logic        ovf,
                                             input logic [2:0]  idx);
        logic [7:0] r;
        case (idx)
            3'd0:    r = ovf ? 8'h4F : hex_ascii(val[15:12]);
            3'd1:    r = ovf ? 8'h46 : hex_ascii(val[11:8]);
            3'd2:    r = ovf ? 8'h4C : hex_ascii(val[7:4]);
            3'd3:    r = ovf ? 8'h4F : hex_ascii(val[3:0]);
            3'd4:    r = 8'h0D;
            3'd5:    r = 8'h0A;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    // Character currently being framed, from the values latched at start.
    always_comb begin
        cur_byte_s = line_byte(value_r, oflo_r, char_idx_r);
    end

    // Transmit FSM: framing, bit timing and registered tx/busy/done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            baud_cnt_r <= CNT_ZERO;
            bit_idx_r  <= 3'd0;
            char_idx_r <= 3'd0;
            value_r    <= 16'h0000;
            oflo_r     <= 1'b0;
            tx_r       <= 1'b1;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    baud_cnt_r <= CNT_ZERO;
                    bit_idx_r  <= 3'd0;
                    char_idx_r <= 3'd0;
                    if (start) begin
                        value_r <= result16;
                        oflo_r  <= oflo;
                        state_r <= START;
                        tx_r    <= 1'b0;
                        busy_r  <= 1'b1;
                    end else begin
                        tx_r   <= 1'b1;
                        busy_r <= 1'b0;
                    end
                end
                START: begin
                    if (baud_cnt_r == CNT_LAST) begin
                        baud_cnt_r <= CNT_ZERO;
                        bit_idx_r  <= 3'd0;
                        state_r    <= DATA;
                        tx_r       <= cur_byte_s[0];
                    end else begin
                        baud_cnt_r <= baud_cnt_r + CNT_ONE;
                    end
                end
                DATA: begin
                    if (baud_cnt_r == CNT_LAST) begin
                        baud_cnt_r <= CNT_ZERO;
                        if (bit_idx_r == 3'd7) begin
                            bit_idx_r <= 3'd0;
                            state_r   <= STOP;
                            tx_r      <= 1'b1;
                        end else begin
                            bit_idx_r <= bit_idx_r + 3'd1;
                            tx_r      <= cur_byte_s[bit_idx_r + 3'd1];
                        end
                    end else begin
                        baud_cnt_r <= baud_cnt_r + CNT_ONE;
                    end
                end
                STOP: begin
                    if ((char_idx_r == 3'd5) && (baud_cnt_r == CNT_PRE)) begin
                        baud_cnt_r <= CNT_ZERO;
                        char_idx_r <= 3'd0;
                        state_r    <= IDLE;
                        busy_r     <= 1'b0;
                        done_r     <= 1'b1;
                        tx_r       <= 1'b1;
                    end else if (baud_cnt_r == CNT_LAST) begin
                        baud_cnt_r <= CNT_ZERO;
                        char_idx_r <= char_idx_r + 3'd1;
                        state_r    <= START;
                        tx_r       <= 1'b0;
                    end else begin
                        baud_cnt_r <= baud_cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    baud_cnt_r <= CNT_ZERO;
                    bit_idx_r  <= 3'd0;
                    char_idx_r <= 3'd0;
                    tx_r       <= 1'b1;
                    busy_r     <= 1'b0;
                end
            endcase
        end
    end

    assign tx   = tx_r;
    assign busy = busy_r;
    assign done = done_r;

endmodule

// File: tb/tb_dot_result_uart_tx.sv
// Directed bench for dot_result_uart_tx with BAUD_DIV = 10. A line receiver
// samples every cycle on the falling edge, decodes each framed byte and checks
// bit width, framing, busy and the position of the single done pulse.

module tb_dot_result_uart_tx;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] result16;
    logic        oflo;
    logic        tx;
    logic        busy;
    logic        done;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    dot_result_uart_tx #(.CLK_FREQ(1000), .BAUD(100)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .result16 (result16),
        .oflo     (oflo),
        .tx       (tx),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Free-running cycle counter used to measure latencies.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_chk(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk({tag, "_tx"}, {31'd0, tx}, 32'd1);
            chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
            chk({tag, "_done"}, {31'd0, done}, 32'd0);
        end
    endtask

    // Called at a falling edge; the start bit is seen on that same edge.
    task automatic pulse(input logic [15:0] v, input logic ov);
        result16 = v;
        oflo     = ov;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
    endtask

    // Receive one 6-byte line, starting at the current falling edge.
    task automatic rx_line(input logic [47:0] exp_line, input string tag,
                           input int max_wait, output int first_cyc, output int done_cyc);
        int waited, width_err, frame_err, busy_err, done_cnt, done_pos, idx;
        logic [7:0] byte_v;
        logic       bit_v;
        waited = 0; width_err = 0; frame_err = 0; busy_err = 0;
        done_cnt = 0; done_pos = -1; first_cyc = -1; done_cyc = -1;
        bit_v = 1'b1;
        while (tx !== 1'b0 && waited < max_wait) begin
            @(negedge clk);
            waited++;
        end
        chk({tag, "_start_seen"}, {31'd0, tx}, 32'd0);
        if (tx !== 1'b0) return;
        first_cyc = cyc;
        for (int c = 0; c < 6; c++) begin
            byte_v = 8'h00;
            for (int b = 0; b < 10; b++) begin
                for (int k = 0; k < 10; k++) begin
                    idx = c * 100 + b * 10 + k;
                    if (idx != 0) @(negedge clk);
                    if (k == 0) bit_v = tx;
                    else if (tx !== bit_v) width_err++;
                    if (idx == 599) begin
                        if (busy !== 1'b0) busy_err++;
                    end else if (busy !== 1'b1) busy_err++;
                    if (done === 1'b1) begin
                        done_cnt++;
                        done_pos = idx;
                        done_cyc = cyc;
                    end
                end
                if (b == 0 && bit_v !== 1'b0) frame_err++;
                if (b == 9 && bit_v !== 1'b1) frame_err++;
                if (b >= 1 && b <= 8) byte_v[b-1] = bit_v;
            end
            chk($sformatf("%s_byte%0d", tag, c), {24'd0, byte_v}, {24'd0, exp_line[47-8*c -: 8]});
        end
        chk({tag, "_bit_width"}, width_err, 32'd0);
        chk({tag, "_framing"}, frame_err, 32'd0);
        chk({tag, "_busy"}, busy_err, 32'd0);
        chk({tag, "_done_count"}, done_cnt, 32'd1);
        chk({tag, "_done_pos"}, done_pos, 32'd599);
    endtask

    initial begin
        int f_a, d_a, f_b, d_b, n;
        rst_n = 1'b0; start = 1'b0; result16 = 16'h0000; oflo = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_tx", {31'd0, tx}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        rst_n = 1'b1;

        // 1: idle after reset
        idle_chk("idle", 50);

        // 2: hex line 0x1A2F
        pulse(16'h1A2F, 1'b0);
        rx_line(48'h3141_3246_0D0A, "hex", 2, f_a, d_a);
        chk("hex_line_time", d_a - f_a, 32'd599);
        idle_chk("after_hex", 5);

        // 3: overflow line; inputs change after acceptance
        pulse(16'hFFFF, 1'b1);
        oflo = 1'b0; result16 = 16'h1234;
        rx_line(48'h4F46_4C4F_0D0A, "oflo", 2, f_a, d_a);
        idle_chk("after_oflo", 5);

        // 4: start while busy is ignored and inputs stay latched
        pulse(16'h0000, 1'b0);
        fork
            rx_line(48'h3030_3030_0D0A, "latch", 2, f_a, d_a);
            begin
                repeat (99) @(negedge clk);
                result16 = 16'h9999;
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
        join
        idle_chk("after_latch", 30);

        // 5: start in the done cycle gives back-to-back lines
        pulse(16'h7E05, 1'b0);
        fork
            rx_line(48'h3745_3035_0D0A, "b2b_a", 2, f_a, d_a);
            begin
                n = 0;
                while (done !== 1'b1 && n < 700) begin
                    @(negedge clk);
                    n++;
                end
                result16 = 16'hBEEF;
                oflo = 1'b0;
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
        join
        rx_line(48'h4245_4546_0D0A, "b2b_b", 2, f_b, d_b);
        chk("b2b_gap", f_b - d_a, 32'd1);
        idle_chk("after_b2b", 5);

        // 6: asynchronous reset mid-line, then a clean line
        pulse(16'h12A4, 1'b0);
        repeat (250) @(negedge clk);
        chk("pre_reset_tx", {31'd0, tx}, 32'd0);
        chk("pre_reset_busy", {31'd0, busy}, 32'd1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_tx", {31'd0, tx}, 32'd1);
        chk("async_rst_busy", {31'd0, busy}, 32'd0);
        chk("async_rst_done", {31'd0, done}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("in_rst_done", {31'd0, done}, 32'd0);
            chk("in_rst_tx", {31'd0, tx}, 32'd1);
        end
        rst_n = 1'b1;
        idle_chk("after_rst", 10);
        pulse(16'h0C3D, 1'b0);
        rx_line(48'h3043_3344_0D0A, "post_rst", 2, f_a, d_a);
        idle_chk("end", 5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
